// File: rtl/epsc_sched_pkg.sv
// epsc_sched_pkg: shared state, widths and operand bundle
// for the EPSC scheduler slice.
package epsc_sched_pkg;

  localparam int DEF_INT_W  = 32;
  localparam int DEF_FRAC_W = 32;
  localparam int DEF_DATA_W = DEF_INT_W + DEF_FRAC_W;
  localparam int DEF_DT_W   = 4;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic [DEF_INT_W-1:0]  eex;
    logic [DEF_DATA_W-1:0] vmem;
    logic [DEF_DATA_W-1:0] gex;
    logic [DEF_DT_W-1:0]   delta_t;
    logic [DEF_INT_W-1:0]  taumem;
  } operand_t;

endpackage

// File: rtl/epsc_index_counter.sv
// epsc_index_counter: neuron index with load/clear,
// increment and last-index compare.
module epsc_index_counter
  import epsc_sched_pkg::*;
#(
  parameter int AW = DEF_ADDR_W
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        load,
  input  logic        inc,
  input  logic [AW:0] count,
  output logic        last
);

  logic [AW:0] idx;
  logic [AW:0] limit;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx   <= '0;
      limit <= '0;
    end else if (load) begin
      idx   <= '0;
      limit <= count;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == limit - 1'b1);

endmodule

// File: rtl/epsc_scheduler.sv
// epsc_scheduler: time-multiplexes one EPSC datapath over all neurons.
// EPSC_ZERO_SKIP_EN: neurons with gex==0 bypass the datapath.
module epsc_scheduler
  import epsc_sched_pkg::*;
#(
  parameter int INTEGER_WIDTH     = DEF_INT_W,
  parameter int DATA_WIDTH_FRAC   = DEF_FRAC_W,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH      = DEF_DT_W,
  parameter int NEURON_ADDR_WIDTH = DEF_ADDR_W,
  parameter int EPSC_LATENCY      = DEF_LAT
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [NEURON_ADDR_WIDTH:0]   NeuronCount,
  input  logic [INTEGER_WIDTH-1:0]     Eex,
  input  logic [DELTAT_WIDTH-1:0]      DeltaT,
  input  logic [INTEGER_WIDTH-1:0]     Taumem,
  output logic                         RdEn,
  output logic [NEURON_ADDR_WIDTH-1:0] RdAddr,
  input  logic                         RdValid,
  input  logic [DATA_WIDTH-1:0]        Vmem_In,
  input  logic [DATA_WIDTH-1:0]        gex_In,
  output logic [INTEGER_WIDTH-1:0]     U_Eex,
  output logic [DATA_WIDTH-1:0]        U_Vmem,
  output logic [DATA_WIDTH-1:0]        U_gex,
  output logic [DELTAT_WIDTH-1:0]      U_DeltaT,
  output logic [INTEGER_WIDTH-1:0]     U_Taumem,
  input  logic [DATA_WIDTH-1:0]        U_EPSCOut,
  output logic                         WrEn,
  output logic [NEURON_ADDR_WIDTH-1:0] WrAddr,
  output logic [DATA_WIDTH-1:0]        WrData,
  input  logic                         WrReady,
  output logic                         Busy,
  output logic                         Done
);

  localparam int AW = NEURON_ADDR_WIDTH;
  localparam int SW = $clog2(EPSC_LATENCY) + 1;
  localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};
  localparam logic [SW-1:0] SETTLE_END = SW'(EPSC_LATENCY - 1);

  state_t                   state;
  logic [SW-1:0]            settle;
  logic [INTEGER_WIDTH-1:0] cfg_eex;
  logic [DELTAT_WIDTH-1:0]  cfg_dt;
  logic [INTEGER_WIDTH-1:0] cfg_tau;
  logic [AW:0]              n_clamped;
  logic                     load;
  logic                     inc;
  logic                     last;

  assign n_clamped = (NeuronCount > MAX_N) ? MAX_N : NeuronCount;
  assign load      = (state == IDLE) && Start;
  assign inc       = (state == WRITE) && WrReady;

  epsc_index_counter #(
    .AW(AW)
  ) u_idx (
    .Clock(Clock),
    .Reset(Reset),
    .load (load),
    .inc  (inc),
    .count(n_clamped),
    .last (last)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      settle   <= '0;
      cfg_eex  <= '0;
      cfg_dt   <= '0;
      cfg_tau  <= '0;
      RdEn     <= 1'b0;
      RdAddr   <= '0;
      U_Eex    <= '0;
      U_Vmem   <= '0;
      U_gex    <= '0;
      U_DeltaT <= '0;
      U_Taumem <= '0;
      WrEn     <= 1'b0;
      WrAddr   <= '0;
      WrData   <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: if (Start) begin
          cfg_eex <= Eex;
          cfg_dt  <= DeltaT;
          cfg_tau <= Taumem;
          Busy    <= 1'b1;
          RdAddr  <= '0;
          if (n_clamped == '0) begin
            state <= DONE;
          end else begin
            RdEn  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          RdEn  <= 1'b0;
          state <= WAIT_RD;
        end
        WAIT_RD: if (RdValid) begin
`ifdef EPSC_ZERO_SKIP_EN
          if (gex_In == '0) begin
            WrData <= '0;
            WrAddr <= RdAddr;
            WrEn   <= 1'b1;
            state  <= WRITE;
          end else
`endif
          begin
            U_Eex    <= cfg_eex;
            U_Vmem   <= Vmem_In;
            U_gex    <= gex_In;
            U_DeltaT <= cfg_dt;
            U_Taumem <= cfg_tau;
            settle   <= '0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (settle == SETTLE_END) begin
            WrData <= U_EPSCOut;
            WrAddr <= RdAddr;
            WrEn   <= 1'b1;
            state  <= WRITE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        WRITE: if (WrReady) begin
          WrEn <= 1'b0;
          if (last) begin
            state <= DONE;
          end else begin
            RdAddr <= RdAddr + 1'b1;
            RdEn   <= 1'b1;
            state  <= FETCH;
          end
        end
        DONE: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
